// File: rtl/alpha_recursion_ctrl_if.sv
// Bundle between the alpha recursion sequencer and its frame control, branch-metric
// buffer, alpha_element and alpha buffer.
interface alpha_recursion_ctrl_if #(
  parameter int BITS           = 32,
  parameter int STATES         = 4,
  parameter int OUTPUT_SYMBOLS = 4,
  parameter int ADDR_BITS      = 10
);
  logic                                 start;
  logic                                 abort;
  logic [ADDR_BITS-1:0]                 frame_len;
  logic                                 busy;
  logic                                 done;
  logic                                 error;
  logic                                 bm_rd_en;
  logic [ADDR_BITS-1:0]                 bm_rd_addr;
  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]  bm_rd_data;
  logic                                 elem_in_valid;
  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]  elem_branch_metric;
  logic [STATES-1:0][BITS-1:0]          elem_prev_alpha;
  logic                                 elem_out_valid;
  logic [STATES-1:0][BITS-1:0]          elem_alpha;
  logic                                 alpha_wr_en;
  logic [ADDR_BITS-1:0]                 alpha_wr_addr;
  logic [STATES-1:0][BITS-1:0]          alpha_wr_data;

  modport master (
    input  start, abort, frame_len, bm_rd_data, elem_out_valid, elem_alpha,
    output busy, done, error, bm_rd_en, bm_rd_addr, elem_in_valid,
           elem_branch_metric, elem_prev_alpha, alpha_wr_en, alpha_wr_addr, alpha_wr_data
  );

  modport slave (
    output start, abort, frame_len, bm_rd_data, elem_out_valid, elem_alpha,
    input  busy, done, error, bm_rd_en, bm_rd_addr, elem_in_valid,
           elem_branch_metric, elem_prev_alpha, alpha_wr_en, alpha_wr_addr, alpha_wr_data
  );
endinterface

// File: rtl/alpha_recursion_ctrl.sv
// Forward (alpha) recursion sequencer: steps one alpha_element across a frame,
// closes its alpha feedback loop and writes alpha[0..N] into the alpha buffer.
module alpha_recursion_ctrl #(
  parameter int             BITS             = 32,
  parameter int             STATES           = 4,
  parameter int             OUTPUT_SYMBOLS   = 4,
  parameter int             ADDR_BITS        = 10,
  parameter int             ELEM_LATENCY     = 4,
  parameter int             TIMEOUT          = 64,
  parameter logic [BITS-1:0] ALPHA_INIT_START = 32'h3F80_0000,
  parameter logic [BITS-1:0] ALPHA_INIT_OTHER = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alpha_recursion_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    READ   = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  typedef logic [STATES-1:0][BITS-1:0] alpha_t;

  // A TIMEOUT not above the element latency is clamped so a healthy element can always answer.
  localparam int TIMEOUT_EFF = (TIMEOUT > ELEM_LATENCY) ? TIMEOUT : (ELEM_LATENCY + 1);
  localparam int TW          = $clog2(TIMEOUT_EFF + 1);

  function automatic alpha_t init_alpha();
    alpha_t v;
    for (int s = 0; s < STATES; s++) begin
      v[s] = (s == 0) ? ALPHA_INIT_START : ALPHA_INIT_OTHER;
    end
    return v;
  endfunction

  state_t               state_r, state_s;
  logic [ADDR_BITS-1:0] n_r, n_s, k_r, k_s;
  logic [TW-1:0]        tcnt_r, tcnt_s;
  alpha_t               alpha_r, alpha_s;
  logic                 busy_r, busy_s, done_r, done_s, error_r, error_s;
  logic                 rd_en_r, rd_en_s, in_valid_r, in_valid_s, wr_en_r, wr_en_s;
  logic [ADDR_BITS-1:0] rd_addr_r, rd_addr_s, wr_addr_r, wr_addr_s;
  alpha_t               prev_alpha_r, prev_alpha_s, wr_data_r, wr_data_s;
  logic                 accept_s, hit_s, expire_s, last_s;

  assign accept_s = (state_r == IDLE) && bus.start;
  assign hit_s    = (state_r == WAIT) && bus.elem_out_valid && !bus.abort;
  assign expire_s = (state_r == WAIT) && !bus.elem_out_valid && !bus.abort &&
                    (tcnt_r == TW'(TIMEOUT_EFF - 1));
  assign last_s   = ((k_r + ADDR_BITS'(1'b1)) == n_r);

  // Next-state selection; abort wins over everything except an IDLE start.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = INIT;
        else           state_s = IDLE;
      end
      INIT: begin
        if (bus.abort)                        state_s = IDLE;
        else if (n_r != {ADDR_BITS{1'b0}})    state_s = READ;
        else                                  state_s = FINISH;
      end
      READ: begin
        if (bus.abort) state_s = IDLE;
        else           state_s = ISSUE;
      end
      ISSUE: begin
        if (bus.abort) state_s = IDLE;
        else           state_s = WAIT;
      end
      WAIT: begin
        if (bus.abort)               state_s = IDLE;
        else if (bus.elem_out_valid) state_s = last_s ? FINISH : READ;
        else if (expire_s)           state_s = IDLE;
        else                         state_s = WAIT;
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output, derived from the next state.
  always_comb begin
    n_s          = n_r;
    k_s          = k_r;
    tcnt_s       = tcnt_r;
    alpha_s      = alpha_r;
    error_s      = error_r;
    wr_addr_s    = wr_addr_r;
    wr_data_s    = wr_data_r;
    rd_addr_s    = rd_addr_r;
    busy_s       = (state_s != IDLE);
    done_s       = (state_s == FINISH);
    rd_en_s      = (state_s == READ);
    in_valid_s   = (state_s == ISSUE);
    wr_en_s      = (state_s == INIT) || hit_s;
    prev_alpha_s = in_valid_s ? alpha_r : '0;

    if (accept_s) begin
      n_s     = bus.frame_len;
      k_s     = {ADDR_BITS{1'b0}};
      alpha_s = init_alpha();
      error_s = 1'b0;
    end else if (hit_s) begin
      k_s     = k_r + ADDR_BITS'(1'b1);
      alpha_s = bus.elem_alpha;
    end else if (expire_s) begin
      error_s = 1'b1;
    end else begin
      k_s     = k_r;
    end

    if (state_s == INIT) begin
      wr_addr_s = {ADDR_BITS{1'b0}};
      wr_data_s = init_alpha();
    end else if (hit_s) begin
      wr_addr_s = k_s;
      wr_data_s = bus.elem_alpha;
    end else begin
      wr_addr_s = wr_addr_r;
    end

    if (rd_en_s) rd_addr_s = k_s;
    else         rd_addr_s = rd_addr_r;

    // The timeout counter reads 0 during ISSUE and counts every cycle after it.
    if (state_s == ISSUE)                          tcnt_s = {TW{1'b0}};
    else if ((state_r == ISSUE) || (state_r == WAIT)) tcnt_s = tcnt_r + TW'(1'b1);
    else                                           tcnt_s = tcnt_r;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      n_r          <= {ADDR_BITS{1'b0}};
      k_r          <= {ADDR_BITS{1'b0}};
      tcnt_r       <= {TW{1'b0}};
      alpha_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      rd_en_r      <= 1'b0;
      in_valid_r   <= 1'b0;
      wr_en_r      <= 1'b0;
      rd_addr_r    <= {ADDR_BITS{1'b0}};
      wr_addr_r    <= {ADDR_BITS{1'b0}};
      prev_alpha_r <= '0;
      wr_data_r    <= '0;
    end else begin
      state_r      <= state_s;
      n_r          <= n_s;
      k_r          <= k_s;
      tcnt_r       <= tcnt_s;
      alpha_r      <= alpha_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= error_s;
      rd_en_r      <= rd_en_s;
      in_valid_r   <= in_valid_s;
      wr_en_r      <= wr_en_s;
      rd_addr_r    <= rd_addr_s;
      wr_addr_r    <= wr_addr_s;
      prev_alpha_r <= prev_alpha_s;
      wr_data_r    <= wr_data_s;
    end
  end

  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.error           = error_r;
  assign bus.bm_rd_en        = rd_en_r;
  assign bus.bm_rd_addr      = rd_addr_r;
  assign bus.elem_in_valid   = in_valid_r;
  assign bus.elem_prev_alpha = prev_alpha_r;
  assign bus.alpha_wr_en     = wr_en_r;
  assign bus.alpha_wr_addr   = wr_addr_r;
  assign bus.alpha_wr_data   = wr_data_r;
  // Read data arrives in the ISSUE cycle itself, so it is gated through rather than registered.
  assign bus.elem_branch_metric = in_valid_r ? bus.bm_rd_data : '0;

endmodule

// File: tb/tb_alpha_recursion_ctrl.sv
// Self-checking bench for alpha_recursion_ctrl with a behavioural stand-in element,
// a branch-metric memory and a write scoreboard.
module tb_alpha_recursion_ctrl;
  localparam int BITS = 32, STATES = 4, OS = 4, AB = 10, L = 4, TO = 64;

  typedef logic [STATES-1:0][BITS-1:0] alpha_t;
  typedef logic [OS-1:0][BITS-1:0]     bm_t;
  typedef struct { logic [AB-1:0] addr; alpha_t data; int cyc; } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  int   t0 = 0;
  int   rd_cnt = 0, iv_cnt = 0;
  wr_t  exp_q[$];
  wr_t  wr_log[$];
  int   done_log[$];
  bm_t  bm_mem [16];
  logic stub_en = 1'b1;
  logic spur = 1'b0;
  logic [L-1:0] pv = '0;
  alpha_t pd [L];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alpha_recursion_ctrl_if #(.BITS(BITS), .STATES(STATES), .OUTPUT_SYMBOLS(OS), .ADDR_BITS(AB)) bus ();

  alpha_recursion_ctrl #(
    .BITS(BITS), .STATES(STATES), .OUTPUT_SYMBOLS(OS), .ADDR_BITS(AB),
    .ELEM_LATENCY(L), .TIMEOUT(TO),
    .ALPHA_INIT_START(32'h3F80_0000), .ALPHA_INIT_OTHER(32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  function automatic alpha_t elem_model(alpha_t p, bm_t b);
    alpha_t r;
    for (int s = 0; s < STATES; s++) r[s] = (p[s] ^ 32'h5A5A_0000) + b[s % OS] + 32'(s);
    return r;
  endfunction

  function automatic alpha_t init_vec();
    alpha_t v = '0;
    v[0] = 32'h3F80_0000;
    return v;
  endfunction

  // Fixed-latency stand-in for alpha_element.
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], bus.elem_in_valid};
    pd[0] <= elem_model(bus.elem_prev_alpha, bus.elem_branch_metric);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign bus.elem_out_valid = (pv[L-1] & stub_en) | spur;
  assign bus.elem_alpha     = pd[L-1];

  // Branch-metric buffer with one cycle of read latency.
  always @(posedge clk) if (bus.bm_rd_en) bus.bm_rd_data <= bm_mem[bus.bm_rd_addr[3:0]];

  // Event recorder.
  always @(negedge clk) begin
    if (bus.done) done_log.push_back(cyc);
    if (bus.bm_rd_en) rd_cnt++;
    if (bus.elem_in_valid) iv_cnt++;
    if (bus.alpha_wr_en) wr_log.push_back('{bus.alpha_wr_addr, bus.alpha_wr_data, cyc});
  end

  // Drives one start pulse and pushes the first nw expected writes of the frame.
  task automatic start_frame(input int n, input int nw);
    alpha_t a;
    @(negedge clk);
    bus.frame_len = AB'(n);
    bus.start = 1'b1;
    t0 = cyc;
    exp_q.delete();
    a = init_vec();
    exp_q.push_back('{AB'(0), a, t0 + 1});
    for (int k = 0; k < n; k++) begin
      a = elem_model(a, bm_mem[k]);
      exp_q.push_back('{AB'(k + 1), a, t0 + 2 + (k + 1) * (L + 2)});
    end
    while (exp_q.size() > nw) void'(exp_q.pop_back());
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_until(input int rel);
    while (cyc < t0 + rel) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.done, bus.error, bus.bm_rd_en, bus.elem_in_valid, bus.alpha_wr_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 000000",
               {bus.busy, bus.done, bus.error, bus.bm_rd_en, bus.elem_in_valid, bus.alpha_wr_en});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.bm_rd_addr, bus.alpha_wr_addr} !== '0 || bus.alpha_wr_data !== '0 ||
        bus.elem_prev_alpha !== '0 || bus.elem_branch_metric !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got rd_addr=%0d wr_addr=%0d wr_data=%h prev=%h bm=%h busy=%b, expected all 0",
               bus.bm_rd_addr, bus.alpha_wr_addr, bus.alpha_wr_data, bus.elem_prev_alpha,
               bus.elem_branch_metric, bus.busy);
    end
  endtask

  task automatic test_single_frame();
    int wb = wr_log.size(), db = done_log.size(), rb = rd_cnt, ib = iv_cnt;
    start_frame(3, 4);
    wait_until(20);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL single_finish: got busy=%b done=%b, expected 1 1", bus.busy, bus.done);
    end
    wait_until(21);
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b, expected 0", bus.busy); end
    wait_until(30);
    n_tests++;
    if (wr_log.size() - wb !== exp_q.size()) begin
      n_fail++; $display("FAIL single_wr_count: got %0d, expected %0d", wr_log.size() - wb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_log.size(); i++) begin
      n_tests++;
      if (wr_log[wb+i].addr !== exp_q[i].addr || wr_log[wb+i].data !== exp_q[i].data || wr_log[wb+i].cyc !== exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL single_wr%0d: got addr=%0d data=%h rel=%0d, expected addr=%0d data=%h rel=%0d", i,
                 wr_log[wb+i].addr, wr_log[wb+i].data, wr_log[wb+i].cyc - t0, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc - t0);
      end
    end
    n_tests++;
    if (done_log.size() - db !== 1 || done_log[db] !== t0 + 20) begin
      n_fail++; $display("FAIL single_done: got %0d pulses first rel=%0d, expected 1 at 20",
                         done_log.size() - db, (done_log.size() > db) ? done_log[db] - t0 : -1);
    end
    n_tests++;
    if (rd_cnt - rb !== 3 || iv_cnt - ib !== 3) begin
      n_fail++; $display("FAIL single_strobes: got rd=%0d iv=%0d, expected 3 3", rd_cnt - rb, iv_cnt - ib);
    end
  endtask

  task automatic test_zero_len();
    int wb = wr_log.size(), db = done_log.size(), rb = rd_cnt, ib = iv_cnt;
    start_frame(0, 1);
    wait_until(10);
    n_tests++;
    if (wr_log.size() - wb !== 1 || wr_log[wb].addr !== exp_q[0].addr || wr_log[wb].data !== exp_q[0].data ||
        wr_log[wb].cyc !== exp_q[0].cyc) begin
      n_fail++; $display("FAIL zero_write: got %0d writes, expected 1 of addr 0 init vector at rel 1", wr_log.size() - wb);
    end
    n_tests++;
    if (done_log.size() - db !== 1 || done_log[db] !== t0 + 2) begin
      n_fail++; $display("FAIL zero_done: got %0d pulses, expected 1 at rel 2", done_log.size() - db);
    end
    n_tests++;
    if (rd_cnt - rb !== 0 || iv_cnt - ib !== 0) begin
      n_fail++; $display("FAIL zero_strobes: got rd=%0d iv=%0d, expected 0 0", rd_cnt - rb, iv_cnt - ib);
    end
  endtask

  task automatic test_timeout();
    int wb = wr_log.size(), db = done_log.size(), ib = iv_cnt;
    stub_en = 1'b0;
    start_frame(2, 1);
    wait_until(3 + TO - 1);
    n_tests++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: got error=%b busy=%b, expected 0 1", bus.error, bus.busy);
    end
    wait_until(3 + TO);
    n_tests++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flag: got error=%b busy=%b, expected 1 0", bus.error, bus.busy);
    end
    wait_until(3 + TO + 12);
    n_tests++;
    if (wr_log.size() - wb !== 1 || wr_log[wb].addr !== exp_q[0].addr || wr_log[wb].data !== exp_q[0].data) begin
      n_fail++; $display("FAIL timeout_writes: got %0d writes, expected only address 0", wr_log.size() - wb);
    end
    n_tests++;
    if (done_log.size() - db !== 0 || iv_cnt - ib !== 1 || bus.error !== 1'b1) begin
      n_fail++; $display("FAIL timeout_after: got done=%0d iv=%0d error=%b, expected 0 1 1",
                         done_log.size() - db, iv_cnt - ib, bus.error);
    end
    stub_en = 1'b1;
  endtask

  task automatic test_abort();
    int wb = wr_log.size(), db = done_log.size();
    start_frame(5, 2);
    wait_until(2);
    n_tests++;
    if (bus.error !== 1'b0) begin n_fail++; $display("FAIL abort_err_clear: got %b, expected 0", bus.error); end
    wait_until(11);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b error=%b, expected 0 0", bus.busy, bus.error);
    end
    wait_until(30);
    n_tests++;
    if (wr_log.size() - wb !== exp_q.size() || done_log.size() - db !== 0) begin
      n_fail++; $display("FAIL abort_count: got writes=%0d done=%0d, expected 2 0", wr_log.size() - wb, done_log.size() - db);
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_log.size(); i++) begin
      n_tests++;
      if (wr_log[wb+i].addr !== exp_q[i].addr || wr_log[wb+i].data !== exp_q[i].data || wr_log[wb+i].cyc !== exp_q[i].cyc) begin
        n_fail++; $display("FAIL abort_wr%0d: got addr=%0d rel=%0d, expected addr=%0d rel=%0d", i,
                           wr_log[wb+i].addr, wr_log[wb+i].cyc - t0, exp_q[i].addr, exp_q[i].cyc - t0);
      end
    end
    wb = wr_log.size();
    db = done_log.size();
    start_frame(1, 2);
    wait_until(15);
    n_tests++;
    if (wr_log.size() - wb !== 2 || done_log.size() - db !== 1 || done_log[db] !== t0 + 8) begin
      n_fail++; $display("FAIL after_abort_count: got writes=%0d done=%0d, expected 2 1 at rel 8",
                         wr_log.size() - wb, done_log.size() - db);
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_log.size(); i++) begin
      n_tests++;
      if (wr_log[wb+i].addr !== exp_q[i].addr || wr_log[wb+i].data !== exp_q[i].data || wr_log[wb+i].cyc !== exp_q[i].cyc) begin
        n_fail++; $display("FAIL after_abort_wr%0d: got addr=%0d data=%h, expected addr=%0d data=%h", i,
                           wr_log[wb+i].addr, wr_log[wb+i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_ignore();
    int wb = wr_log.size(), db = done_log.size();
    start_frame(3, 4);
    wait_until(5);
    bus.frame_len = AB'(1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(8);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    wait_until(30);
    n_tests++;
    if (wr_log.size() - wb !== exp_q.size() || done_log.size() - db !== 1 || done_log[db] !== t0 + 20) begin
      n_fail++; $display("FAIL ignore_count: got writes=%0d done=%0d, expected 4 1 at rel 20",
                         wr_log.size() - wb, done_log.size() - db);
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_log.size(); i++) begin
      n_tests++;
      if (wr_log[wb+i].addr !== exp_q[i].addr || wr_log[wb+i].data !== exp_q[i].data || wr_log[wb+i].cyc !== exp_q[i].cyc) begin
        n_fail++; $display("FAIL ignore_wr%0d: got addr=%0d data=%h rel=%0d, expected addr=%0d data=%h rel=%0d", i,
                           wr_log[wb+i].addr, wr_log[wb+i].data, wr_log[wb+i].cyc - t0, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc - t0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wb = wr_log.size(), db = done_log.size(), rb;
    start_frame(3, 1);
    wait_until(5);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.error, bus.bm_rd_en, bus.elem_in_valid, bus.alpha_wr_en} !== 6'b0 ||
        bus.alpha_wr_data !== '0 || bus.elem_prev_alpha !== '0 || bus.elem_branch_metric !== '0 ||
        bus.bm_rd_addr !== '0 || bus.alpha_wr_addr !== '0) begin
      n_fail++; $display("FAIL reset_mid_async: got busy=%b wr_data=%h wr_addr=%0d, expected all 0",
                         bus.busy, bus.alpha_wr_data, bus.alpha_wr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rb = rd_cnt;
    repeat (12) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || rd_cnt - rb !== 0 || wr_log.size() - wb !== 1 || done_log.size() - db !== 0) begin
      n_fail++; $display("FAIL reset_mid_idle: got busy=%b rd=%0d writes=%0d done=%0d, expected 0 0 1 0",
                         bus.busy, rd_cnt - rb, wr_log.size() - wb, done_log.size() - db);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.frame_len = '0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < OS; j++) bm_mem[i][j] = $urandom | 32'h0000_0001;
    test_reset();
    test_single_frame();
    test_zero_len();
    test_timeout();
    test_abort();
    test_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
